mem_responder: RTL and testbench

//   Main-memory model at the responder (downstream) end of the MemBus protocol; the cache's tx_bp connects here.

---
 rtl/cache_pkg.sv | 13 +
 rtl/mem_responder_if.sv | 28 ++
 rtl/mem_responder.sv | 145 ++++++++++++++
 tb/tb_mem_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared MemBus types and widths used by the cache and the memory responder.
package cache_pkg;

    localparam int ADDR_WIDTH = 6;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        Op_INVALID = 2'd0,
        Op_READ    = 2'd1,
        Op_WRITE   = 2'd2
    } Op;

endpackage

// File: rtl/mem_responder_if.sv
// MemBus: single-cycle requests from the cache (master) to memory (slave),
// registered read responses flowing back.
interface mem_responder_if;
    import cache_pkg::*;

    Op                       req_op;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_data;
    logic                    rsp_vld;
    logic [DATA_WIDTH-1:0]   rsp_data;

    modport master (
        output req_op,
        output req_addr,
        output req_data,
        input  rsp_vld,
        input  rsp_data
    );

    modport slave (
        input  req_op,
        input  req_addr,
        input  req_data,
        output rsp_vld,
        output rsp_data
    );

endinterface

// File: rtl/mem_responder.sv
// Main-memory model at the downstream end of MemBus. Accepts one request per
// cycle with no back-pressure; writes commit at the acceptance edge, reads
// return through a fixed-depth valid/data pipeline so responses come back in
// order exactly LATENCY cycles after the request.
module mem_responder
    import cache_pkg::*;
#(
    parameter int LATENCY   = 2,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  rx_bp,
    output logic [31:0]     rd_count,
    output logic [31:0]     wr_count,
    output logic [3:0]      inflight
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  rd_acc;
    logic                  wr_acc;
    logic                  bad_op;
    logic [DATA_WIDTH-1:0] rd_sample;

    // Stage i of the read pipeline; the last stage is what the bus sees.
    logic                  vld_p  [LATENCY];
    logic [DATA_WIDTH-1:0] data_p [LATENCY];

    logic                  pipe_enter;
    logic                  pipe_exit;

    // Request decode: anything other than READ/WRITE is treated as idle.
    always_comb begin
        rd_acc    = 1'b0;
        wr_acc    = 1'b0;
        bad_op    = 1'b0;
        rd_sample = mem[rx_bp.req_addr];
        if (!rst) begin
            case (rx_bp.req_op)
                Op_READ:    rd_acc = 1'b1;
                Op_WRITE:   wr_acc = 1'b1;
                Op_INVALID: ;
                default:    bad_op = 1'b1;
            endcase
        end
    end

    // Storage array: optional clear on reset, otherwise commit writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (INIT_ZERO) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
            end
        end else if (wr_acc) begin
            mem[rx_bp.req_addr] <= rx_bp.req_data;
        end
    end

    // Valid pipeline: reset drops every in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_p[i] <= 1'b0;
            end
        end else begin
            vld_p[0] <= rd_acc;
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Data pipeline: a stage only loads when a valid read moves into it, so the
    // output stage holds its last value between pulses.
    always_ff @(posedge clk) begin
        for (int i = LATENCY - 1; i >= 1; i--) begin
            if (vld_p[i-1]) begin
                data_p[i] <= data_p[i-1];
            end
        end
        if (rd_acc) begin
            data_p[0] <= rd_sample;
        end
        if (rst) begin
            data_p[LATENCY-1] <= '0;
        end
    end

    assign rx_bp.rsp_vld  = vld_p[LATENCY-1];
    assign rx_bp.rsp_data = data_p[LATENCY-1];

    // With a single stage the accepted read is presented immediately, so it
    // never counts as in flight.
    generate
        if (LATENCY > 1) begin : g_deep
            assign pipe_enter = rd_acc;
            assign pipe_exit  = vld_p[LATENCY-2];
        end else begin : g_shallow
            assign pipe_enter = 1'b0;
            assign pipe_exit  = 1'b0;
        end
    endgenerate

    // Accounting counters; all wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
            inflight <= '0;
        end else begin
            if (rd_acc) begin
                rd_count <= rd_count + 32'd1;
            end
            if (wr_acc) begin
                wr_count <= wr_count + 32'd1;
            end
            case ({pipe_enter, pipe_exit})
                2'b10:   inflight <= inflight + 4'd1;
                2'b01:   inflight <= inflight - 4'd1;
                default: inflight <= inflight;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Simulation trace of accepted requests and unknown opcodes.
    always_ff @(posedge clk) begin
        if (rd_acc) begin
            $display("mem op=%s addr=0x%h data=0x%h", "READ", rx_bp.req_addr, rd_sample);
        end
        if (wr_acc) begin
            $display("mem op=%s addr=0x%h data=0x%h", "WRITE", rx_bp.req_addr, rx_bp.req_data);
        end
        if (bad_op) begin
            $display("mem warning: unknown op encoding %0d ignored", rx_bp.req_op);
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 2, 3 and 1) sharing clock
// and reset; each scenario drives one instance and checks it inline.
module tb_mem_responder;
    import cache_pkg::*;

    localparam int LAT2  = 2;
    localparam int LAT3  = 3;
    localparam int LAT1  = 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic clk;
    logic rst;

    mem_responder_if bus2 ();
    mem_responder_if bus3 ();
    mem_responder_if bus1 ();

    logic [31:0] rd2, wr2, rd3, wr3, rd1, wr1;
    logic [3:0]  inf2, inf3, inf1;

    mem_responder #(.LATENCY(LAT2), .INIT_ZERO(1'b1)) dut2 (
        .clk(clk), .rst(rst), .rx_bp(bus2), .rd_count(rd2), .wr_count(wr2), .inflight(inf2)
    );
    mem_responder #(.LATENCY(LAT3), .INIT_ZERO(1'b1)) dut3 (
        .clk(clk), .rst(rst), .rx_bp(bus3), .rd_count(rd3), .wr_count(wr3), .inflight(inf3)
    );
    mem_responder #(.LATENCY(LAT1), .INIT_ZERO(1'b1)) dut1 (
        .clk(clk), .rst(rst), .rx_bp(bus1), .rd_count(rd1), .wr_count(wr1), .inflight(inf1)
    );

    int ncmp = 0;
    int nerr = 0;
    int cyc  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle_all();
        bus2.req_op = Op_INVALID; bus2.req_addr = '0; bus2.req_data = '0;
        bus3.req_op = Op_INVALID; bus3.req_addr = '0; bus3.req_data = '0;
        bus1.req_op = Op_INVALID; bus1.req_addr = '0; bus1.req_data = '0;
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        ncmp++; if (bus2.rsp_vld !== 1'b0) begin nerr++; $display("FAIL reset_vld2 got=%0b exp=0", bus2.rsp_vld); end
        ncmp++; if (bus2.rsp_data !== 32'h0) begin nerr++; $display("FAIL reset_data2 got=%0h exp=0", bus2.rsp_data); end
        ncmp++; if (rd2 !== 32'd0) begin nerr++; $display("FAIL reset_rd2 got=%0d exp=0", rd2); end
        ncmp++; if (wr2 !== 32'd0) begin nerr++; $display("FAIL reset_wr2 got=%0d exp=0", wr2); end
        ncmp++; if (inf2 !== 4'd0) begin nerr++; $display("FAIL reset_inflight2 got=%0d exp=0", inf2); end
        ncmp++; if (bus3.rsp_vld !== 1'b0) begin nerr++; $display("FAIL reset_vld3 got=%0b exp=0", bus3.rsp_vld); end
        ncmp++; if (bus1.rsp_data !== 32'h0) begin nerr++; $display("FAIL reset_data1 got=%0h exp=0", bus1.rsp_data); end
    endtask

    task automatic test_read_zero();
        do_reset();
        bus2.req_op = Op_READ; bus2.req_addr = 6'h0;
        tick();
        bus2.req_op = Op_INVALID;
        ncmp++; if (bus2.rsp_vld !== 1'b0) begin nerr++; $display("FAIL rd0_early got=%0b exp=0", bus2.rsp_vld); end
        ncmp++; if (inf2 !== 4'd1) begin nerr++; $display("FAIL rd0_inflight got=%0d exp=1", inf2); end
        tick();
        ncmp++; if (bus2.rsp_vld !== 1'b1) begin nerr++; $display("FAIL rd0_vld got=%0b exp=1", bus2.rsp_vld); end
        ncmp++; if (bus2.rsp_data !== 32'h0) begin nerr++; $display("FAIL rd0_data got=%0h exp=0", bus2.rsp_data); end
        ncmp++; if (rd2 !== 32'd1) begin nerr++; $display("FAIL rd0_count got=%0d exp=1", rd2); end
        tick();
        ncmp++; if (bus2.rsp_vld !== 1'b0) begin nerr++; $display("FAIL rd0_pulse_len got=%0b exp=0", bus2.rsp_vld); end
    endtask

    task automatic test_read_after_write();
        do_reset();
        bus2.req_op = Op_WRITE; bus2.req_addr = 6'h5; bus2.req_data = 32'hA5;
        tick();
        ncmp++; if (bus2.rsp_vld !== 1'b0) begin nerr++; $display("FAIL raw_wr_vld got=%0b exp=0", bus2.rsp_vld); end
        ncmp++; if (wr2 !== 32'd1) begin nerr++; $display("FAIL raw_wr_count got=%0d exp=1", wr2); end
        bus2.req_op = Op_READ; bus2.req_data = 32'h0;
        tick();
        bus2.req_op = Op_INVALID;
        ncmp++; if (bus2.rsp_vld !== 1'b0) begin nerr++; $display("FAIL raw_early got=%0b exp=0", bus2.rsp_vld); end
        tick();
        ncmp++; if (bus2.rsp_vld !== 1'b1) begin nerr++; $display("FAIL raw_vld got=%0b exp=1", bus2.rsp_vld); end
        ncmp++; if (bus2.rsp_data !== 32'hA5) begin nerr++; $display("FAIL raw_data got=%0h exp=a5", bus2.rsp_data); end
        tick();
        ncmp++; if (bus2.rsp_data !== 32'hA5) begin nerr++; $display("FAIL raw_hold got=%0h exp=a5", bus2.rsp_data); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got_data[$];
        int          got_cyc[$];
        int          peak;
        int          start;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            bus2.req_op = Op_WRITE; bus2.req_addr = 6'(i); bus2.req_data = 32'h11 * i;
            tick();
        end
        peak  = 0;
        start = cyc;
        for (int c = 0; c < 10; c++) begin
            if (c < 4) begin
                bus2.req_op = Op_READ; bus2.req_addr = 6'(c + 1); bus2.req_data = '0;
            end else begin
                bus2.req_op = Op_INVALID;
            end
            tick();
            if (bus2.rsp_vld === 1'b1) begin
                got_data.push_back(bus2.rsp_data);
                got_cyc.push_back(cyc - start);
            end
            if (int'(inf2) > peak) peak = int'(inf2);
        end
        ncmp++; if (got_data.size() != 4) begin nerr++; $display("FAIL b2b_count got=%0d exp=4", got_data.size()); end
        for (int k = 0; k < 4 && k < got_data.size(); k++) begin
            ncmp++; if (got_data[k] !== 32'h11 * (k + 1)) begin nerr++; $display("FAIL b2b_data%0d got=%0h exp=%0h", k, got_data[k], 32'h11 * (k + 1)); end
            ncmp++; if (got_cyc[k] != k + LAT2) begin nerr++; $display("FAIL b2b_time%0d got=%0d exp=%0d", k, got_cyc[k], k + LAT2); end
        end
        ncmp++; if (peak != LAT2 - 1) begin nerr++; $display("FAIL b2b_peak_inflight got=%0d exp=%0d", peak, LAT2 - 1); end
    endtask

    task automatic test_reset_inflight();
        int pulses;
        do_reset();
        bus3.req_op = Op_WRITE; bus3.req_addr = 6'h7; bus3.req_data = 32'h77;
        tick();
        bus3.req_op = Op_READ; bus3.req_data = '0;
        tick();
        bus3.req_op = Op_INVALID;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ncmp++; if (rd3 !== 32'd0) begin nerr++; $display("FAIL rstfl_rd got=%0d exp=0", rd3); end
        ncmp++; if (inf3 !== 4'd0) begin nerr++; $display("FAIL rstfl_inflight got=%0d exp=0", inf3); end
        ncmp++; if (wr3 !== 32'd0) begin nerr++; $display("FAIL rstfl_wr got=%0d exp=0", wr3); end
        pulses = (bus3.rsp_vld === 1'b1) ? 1 : 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus3.rsp_vld !== 1'b0) pulses++;
        end
        ncmp++; if (pulses != 0) begin nerr++; $display("FAIL rstfl_pulses got=%0d exp=0", pulses); end
    endtask

    task automatic test_writeback_fill();
        logic [31:0] line [4];
        logic [31:0] got[$];
        do_reset();
        for (int k = 0; k < 4; k++) line[k] = $urandom;
        for (int k = 0; k < 4; k++) begin
            bus2.req_op = Op_WRITE; bus2.req_addr = 6'(6'h20 + k); bus2.req_data = line[k];
            tick();
        end
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                bus2.req_op = Op_READ; bus2.req_addr = 6'(6'h20 + c); bus2.req_data = '0;
            end else begin
                bus2.req_op = Op_INVALID;
            end
            tick();
            if (bus2.rsp_vld === 1'b1) got.push_back(bus2.rsp_data);
        end
        ncmp++; if (got.size() != 4) begin nerr++; $display("FAIL fill_words got=%0d exp=4", got.size()); end
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            ncmp++; if (got[k] !== line[k]) begin nerr++; $display("FAIL fill_word%0d got=%0h exp=%0h", k, got[k], line[k]); end
        end
        ncmp++; if (wr2 !== 32'd4) begin nerr++; $display("FAIL fill_wr got=%0d exp=4", wr2); end
        ncmp++; if (rd2 !== 32'd4) begin nerr++; $display("FAIL fill_rd got=%0d exp=4", rd2); end
    endtask

    task automatic test_unknown_op();
        do_reset();
        bus2.req_op = Op_WRITE; bus2.req_addr = 6'h3; bus2.req_data = 32'h33;
        tick();
        bus2.req_op = Op'(2'd3); bus2.req_data = 32'hFF;
        tick();
        bus2.req_op = Op_INVALID;
        ncmp++; if (wr2 !== 32'd1) begin nerr++; $display("FAIL unk_wr got=%0d exp=1", wr2); end
        ncmp++; if (rd2 !== 32'd0) begin nerr++; $display("FAIL unk_rd got=%0d exp=0", rd2); end
        ncmp++; if (inf2 !== 4'd0) begin nerr++; $display("FAIL unk_inflight got=%0d exp=0", inf2); end
        bus2.req_op = Op_READ; bus2.req_data = '0;
        tick();
        bus2.req_op = Op_INVALID;
        tick();
        ncmp++; if (bus2.rsp_vld !== 1'b1 || bus2.rsp_data !== 32'h33) begin
            nerr++; $display("FAIL unk_mem vld=%0b data=%0h exp vld=1 data=33", bus2.rsp_vld, bus2.rsp_data);
        end
    endtask

    task automatic test_random_sweep();
        logic [31:0] ref_mem [DEPTH];
        int          due_q[$];
        logic [31:0] dat_q[$];
        int          n_rd, n_wr, sel;
        logic [ADDR_WIDTH-1:0] a;
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        n_rd = 0; n_wr = 0;
        for (int c = 0; c < 1004; c++) begin
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                ncmp++; if (bus1.rsp_vld !== 1'b1 || bus1.rsp_data !== dat_q[0]) begin
                    nerr++; $display("FAIL sweep_rsp cyc=%0d vld=%0b data=%0h exp vld=1 data=%0h", cyc, bus1.rsp_vld, bus1.rsp_data, dat_q[0]);
                end
                void'(due_q.pop_front());
                void'(dat_q.pop_front());
            end else begin
                ncmp++; if (bus1.rsp_vld !== 1'b0) begin nerr++; $display("FAIL sweep_idle cyc=%0d vld=%0b exp=0", cyc, bus1.rsp_vld); end
            end
            sel = (c < 1000) ? int'($urandom_range(0, 2)) : 0;
            a   = ADDR_WIDTH'($urandom);
            d   = $urandom;
            bus1.req_addr = a; bus1.req_data = d;
            if (sel == 1) begin
                bus1.req_op = Op_READ;
                due_q.push_back(cyc + LAT1);
                dat_q.push_back(ref_mem[a]);
                n_rd++;
            end else if (sel == 2) begin
                bus1.req_op = Op_WRITE;
                ref_mem[a] = d;
                n_wr++;
            end else begin
                bus1.req_op = Op_INVALID;
            end
            tick();
        end
        bus1.req_op = Op_INVALID;
        ncmp++; if (due_q.size() != 0) begin nerr++; $display("FAIL sweep_lost got=%0d exp=0", due_q.size()); end
        ncmp++; if (rd1 !== 32'(n_rd)) begin nerr++; $display("FAIL sweep_rd got=%0d exp=%0d", rd1, n_rd); end
        ncmp++; if (wr1 !== 32'(n_wr)) begin nerr++; $display("FAIL sweep_wr got=%0d exp=%0d", wr1, n_wr); end
        ncmp++; if (inf1 !== 4'd0) begin nerr++; $display("FAIL sweep_inflight got=%0d exp=0", inf1); end
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        test_reset();
        test_read_zero();
        test_read_after_write();
        test_back_to_back();
        test_reset_inflight();
        test_writeback_fill();
        test_unknown_op();
        test_random_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
